// File: rtl/piso_tx4_if.sv
// Parallel-word load / serial-out bus between a word source and the piso_tx4 transmitter.
interface piso_tx4_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] D;
    logic             LOAD;
    logic             O;
    logic             BUSY;
    logic             DONE;

    modport master (
        output D,
        output LOAD,
        input  O,
        input  BUSY,
        input  DONE
    );

    modport slave (
        input  D,
        input  LOAD,
        output O,
        output BUSY,
        output DONE
    );
endinterface

// File: rtl/piso_tx4.sv
// Parallel-in/serial-out transmitter: emits a WIDTH-bit word LSB-first on falling edges of C,
// with back-to-back reload on the completing edge and a one-period DONE pulse.
module piso_tx4 #(
    parameter int unsigned WIDTH = 4
) (
    input  logic         C,
    input  logic         nCLR,
    piso_tx4_if.slave    bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } stateT;

    stateT            state;
    stateT            stateNext;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sregNext;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntNext;
    logic             oReg;
    logic             oNext;
    logic             busyReg;
    logic             busyNext;
    logic             doneReg;
    logic             doneNext;

    // All state moves on the falling edge of C; nCLR clears everything at once.
    always_ff @(negedge C or negedge nCLR) begin
        if (!nCLR) begin
            state   <= IDLE;
            sreg    <= '0;
            cnt     <= '0;
            oReg    <= 1'b0;
            busyReg <= 1'b0;
            doneReg <= 1'b0;
        end else begin
            state   <= stateNext;
            sreg    <= sregNext;
            cnt     <= cntNext;
            oReg    <= oNext;
            busyReg <= busyNext;
            doneReg <= doneNext;
        end
    end

    // Next-state and next-output logic; DONE is a pulse so it defaults low.
    always_comb begin
        stateNext = state;
        sregNext  = sreg;
        cntNext   = cnt;
        oNext     = oReg;
        busyNext  = busyReg;
        doneNext  = 1'b0;

        case (state)
            IDLE: begin
                oNext    = 1'b0;
                busyNext = 1'b0;
                if (bus.LOAD) begin
                    stateNext = SHIFT;
                    sregNext  = bus.D;
                    oNext     = bus.D[0];
                    cntNext   = '0;
                    busyNext  = 1'b1;
                end
            end

            SHIFT: begin
                if (cnt == LAST_BIT) begin
                    // Last bit's slot ends here: pulse DONE and either chain the next word or stop.
                    doneNext = 1'b1;
                    if (bus.LOAD) begin
                        sregNext = bus.D;
                        oNext    = bus.D[0];
                        cntNext  = '0;
                        busyNext = 1'b1;
                    end else begin
                        stateNext = IDLE;
                        sregNext  = '0;
                        cntNext   = '0;
                        oNext     = 1'b0;
                        busyNext  = 1'b0;
                    end
                end else begin
                    // Present the next bit; LOAD is ignored mid-word.
                    sregNext = sreg >> 1;
                    cntNext  = cnt + CNT_W'(1);
                    oNext    = sreg[1];
                end
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign bus.O    = oReg;
    assign bus.BUSY = busyReg;
    assign bus.DONE = doneReg;

endmodule

// File: tb/tb_piso_tx4.sv
// Bench for piso_tx4: a bit-queue reference model plus a downstream 4-stage shift chain on the same C/nCLR.
module tb_piso_tx4;

    logic       C;
    logic       nCLR;
    logic [3:0] siso;

    piso_tx4_if #(.WIDTH(4)) bus ();

    piso_tx4 #(.WIDTH(4)) dut (
        .C    (C),
        .nCLR (nCLR),
        .bus  (bus)
    );

    initial C = 1'b0;
    always #7 C = ~C;

    // Downstream chain: first bit in ends at siso[0].
    always_ff @(negedge C or negedge nCLR) begin
        if (!nCLR) siso <= 4'b0000;
        else       siso <= {bus.O, siso[3:1]};
    end

    int   nCompared;
    int   nMismatched;

    logic bitQ[$];
    logic [3:0] curWord;
    logic [3:0] doneWord;
    logic expO;
    logic expBusy;
    logic expDone;

    task automatic clear_model();
        bitQ.delete();
        expO    = 1'b0;
        expBusy = 1'b0;
        expDone = 1'b0;
    endtask

    // Drive one falling edge's worth of inputs, advance the model, return at the next rising edge.
    task automatic step(input logic ld, input logic [3:0] d);
        logic finished;
        bus.LOAD = ld;
        bus.D    = d;
        @(negedge C);
        finished = 1'b0;
        if (nCLR) begin
            if (bitQ.size() > 0) begin
                void'(bitQ.pop_front());
                finished = (bitQ.size() == 0);
            end
            if (finished) doneWord = curWord;
            expDone = finished;
            if (bitQ.size() == 0 && ld) begin
                curWord = d;
                for (int i = 0; i < 4; i++) bitQ.push_back(d[i]);
            end
            expO    = (bitQ.size() > 0) ? bitQ[0] : 1'b0;
            expBusy = (bitQ.size() > 0);
        end
        @(posedge C);
    endtask

    task automatic test_reset();
        nCLR     = 1'b1;
        bus.LOAD = 1'b0;
        bus.D    = 4'b0000;
        #3 nCLR  = 1'b0;
        clear_model();
        #1;
        nCompared++;
        if ({bus.O, bus.BUSY, bus.DONE} !== 3'b000) begin
            nMismatched++;
            $display("FAIL reset_outputs: O/BUSY/DONE got %b want 000", {bus.O, bus.BUSY, bus.DONE});
        end
        @(posedge C);
    endtask

    task automatic test_load_during_clear();
        bus.LOAD = 1'b1;
        bus.D    = 4'($urandom());
        @(negedge C);
        #1;
        nCompared++;
        if ({bus.O, bus.BUSY, bus.DONE, siso} !== 7'b0) begin
            nMismatched++;
            $display("FAIL load_in_clear: O/BUSY/DONE/siso got %b want 0000000",
                     {bus.O, bus.BUSY, bus.DONE, siso});
        end
        #4 nCLR = 1'b1;
        @(posedge C);
        for (int i = 0; i < 6; i++) begin
            logic [3:0] d;
            d = (i == 0) ? 4'b1100 : 4'($urandom());
            step(i == 0, d);
            nCompared++;
            if ({bus.O, bus.BUSY, bus.DONE} !== {expO, expBusy, expDone}) begin
                nMismatched++;
                $display("FAIL after_clear step %0d: O/BUSY/DONE got %b want %b",
                         i, {bus.O, bus.BUSY, bus.DONE}, {expO, expBusy, expDone});
            end
            if (i == 4) begin
                nCompared++;
                if ({bus.DONE, siso} !== 5'b1_1100) begin
                    nMismatched++;
                    $display("FAIL after_clear_word: DONE/siso got %b want 11100", {bus.DONE, siso});
                end
            end
        end
    endtask

    task automatic test_single();
        int busyCount;
        int doneCount;
        int doneAt;
        busyCount = 0;
        doneCount = 0;
        doneAt    = -1;
        for (int i = 0; i < 6; i++) begin
            step(i == 0, (i == 0) ? 4'b1011 : 4'($urandom()));
            nCompared++;
            if ({bus.O, bus.BUSY, bus.DONE} !== {expO, expBusy, expDone}) begin
                nMismatched++;
                $display("FAIL single step %0d: O/BUSY/DONE got %b want %b",
                         i, {bus.O, bus.BUSY, bus.DONE}, {expO, expBusy, expDone});
            end
            if (bus.BUSY === 1'b1) busyCount++;
            if (bus.DONE === 1'b1) begin
                doneCount++;
                doneAt = i;
            end
            if (i == 4) begin
                nCompared++;
                if (siso !== 4'b1011) begin
                    nMismatched++;
                    $display("FAIL single_siso: got %b want 1011", siso);
                end
            end
        end
        nCompared++;
        if (busyCount != 4 || doneCount != 1 || doneAt != 4) begin
            nMismatched++;
            $display("FAIL single_timing: busy periods %0d done pulses %0d at %0d, want 4 1 4",
                     busyCount, doneCount, doneAt);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seen;
        logic [8:0] doneMask;
        logic       busyDropped;
        seen        = '0;
        doneMask    = '0;
        busyDropped = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step(i < 8, (i < 4) ? 4'b0110 : 4'b1001);
            nCompared++;
            if ({bus.O, bus.BUSY, bus.DONE} !== {expO, expBusy, expDone}) begin
                nMismatched++;
                $display("FAIL b2b step %0d: O/BUSY/DONE got %b want %b",
                         i, {bus.O, bus.BUSY, bus.DONE}, {expO, expBusy, expDone});
            end
            if (i < 8) begin
                seen[i] = bus.O;
                if (bus.BUSY !== 1'b1) busyDropped = 1'b1;
            end
            doneMask[i] = bus.DONE;
            if (i == 4 || i == 8) begin
                nCompared++;
                if (siso !== ((i == 4) ? 4'b0110 : 4'b1001)) begin
                    nMismatched++;
                    $display("FAIL b2b_siso at %0d: got %b", i, siso);
                end
            end
        end
        nCompared++;
        if (seen !== 8'b1001_0110 || doneMask !== 9'b1_0001_0000 || busyDropped !== 1'b0) begin
            nMismatched++;
            $display("FAIL b2b_stream: bits %b done %b busyDrop %b want 10010110 100010000 0",
                     seen, doneMask, busyDropped);
        end
    endtask

    task automatic test_ignore_load();
        logic [3:0] seen;
        seen = '0;
        for (int i = 0; i < 5; i++) begin
            step(i == 0 || i == 2, (i == 0) ? 4'b0101 : 4'b1111);
            nCompared++;
            if ({bus.O, bus.BUSY, bus.DONE} !== {expO, expBusy, expDone}) begin
                nMismatched++;
                $display("FAIL ignore step %0d: O/BUSY/DONE got %b want %b",
                         i, {bus.O, bus.BUSY, bus.DONE}, {expO, expBusy, expDone});
            end
            if (i < 4) seen[i] = bus.O;
        end
        nCompared++;
        if (seen !== 4'b0101 || siso !== 4'b0101) begin
            nMismatched++;
            $display("FAIL ignore_word: bits %b siso %b want 0101 0101", seen, siso);
        end
    endtask

    task automatic test_clear_mid_word();
        logic doneSeen;
        doneSeen = 1'b0;
        for (int i = 0; i < 3; i++) step(i == 0, (i == 0) ? 4'b1110 : 4'b0111);
        #2 nCLR = 1'b0;
        clear_model();
        #1;
        nCompared++;
        if ({bus.O, bus.BUSY, bus.DONE, siso} !== 7'b0) begin
            nMismatched++;
            $display("FAIL clear_mid: O/BUSY/DONE/siso got %b want 0000000",
                     {bus.O, bus.BUSY, bus.DONE, siso});
        end
        #4 nCLR = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 4'($urandom()));
            nCompared++;
            if ({bus.O, bus.BUSY, bus.DONE} !== {expO, expBusy, expDone}) begin
                nMismatched++;
                $display("FAIL post_clear step %0d: O/BUSY/DONE got %b want %b",
                         i, {bus.O, bus.BUSY, bus.DONE}, {expO, expBusy, expDone});
            end
            if (bus.DONE !== 1'b0) doneSeen = 1'b1;
        end
        nCompared++;
        if (doneSeen !== 1'b0) begin
            nMismatched++;
            $display("FAIL clear_no_done: DONE seen %b want 0", doneSeen);
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 4'($urandom()));
            nCompared++;
            if ({bus.O, bus.BUSY, bus.DONE, siso} !== {expO, expBusy, expDone, 4'b0000}) begin
                nMismatched++;
                $display("FAIL idle step %0d: O/BUSY/DONE/siso got %b want %b",
                         i, {bus.O, bus.BUSY, bus.DONE, siso}, {expO, expBusy, expDone, 4'b0000});
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                #2 nCLR = 1'b0;
                clear_model();
                #1;
                nCompared++;
                if ({bus.O, bus.BUSY, bus.DONE, siso} !== 7'b0) begin
                    nMismatched++;
                    $display("FAIL rand_clear at %0d: O/BUSY/DONE/siso got %b want 0000000",
                             i, {bus.O, bus.BUSY, bus.DONE, siso});
                end
                #2 nCLR = 1'b1;
            end
            step($urandom_range(0, 3) != 0, 4'($urandom()));
            nCompared++;
            if ({bus.O, bus.BUSY, bus.DONE} !== {expO, expBusy, expDone}) begin
                nMismatched++;
                $display("FAIL rand step %0d: O/BUSY/DONE got %b want %b",
                         i, {bus.O, bus.BUSY, bus.DONE}, {expO, expBusy, expDone});
            end
            if (expDone) begin
                nCompared++;
                if (siso !== doneWord) begin
                    nMismatched++;
                    $display("FAIL rand_siso step %0d: got %b want %b", i, siso, doneWord);
                end
            end
        end
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        curWord     = '0;
        doneWord    = '0;
        clear_model();
        test_reset();
        test_load_during_clear();
        test_single();
        test_back_to_back();
        test_ignore_load();
        test_clear_mid_word();
        test_idle();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
